// File: rtl/cam_pixel_capture.sv
// cam_pixel_capture: DVP camera front end. Registers the camera bus once,
// tracks frame/line structure, and forwards the Y (luma) byte of each YUV422
// pixel pair to the downstream write FIFO. Frames that are short, carry a
// line-length error or would overflow the FIFO are abandoned and counted.
//
// Ports:
//   pixel_clk    capture clock (all logic on rising edge)
//   rst          synchronous, active-high reset
//   cam_vsync    frame sync, high during vertical blanking
//   cam_href     line valid, high while line bytes are present
//   cam_data     camera byte, Y first then chroma
//   fifo_full    full flag from the downstream write FIFO
//   word_out     luma word to the FIFO
//   we           write strobe, one cycle per forwarded pixel
//   frame_active high while the current frame is being forwarded
//   frame_done   one-cycle pulse after the last line of a complete frame
//   line_err     one-cycle pulse on a line-length mismatch
//   drop_count   saturating count of discarded frames
//
// Build option: define CAPTURE_DECIMATE_EN for 2x2 decimation (only even
// pixels of even lines are written; length checks still use full lines).
module cam_pixel_capture #(
  parameter int unsigned WORD_WIDTH    = 8,
  parameter int unsigned IMG_WIDTH     = 640,
  parameter int unsigned IMG_HEIGHT    = 480,
  parameter int unsigned DROP_CNT_BITS = 16
) (
  input  logic                     pixel_clk,
  input  logic                     rst,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [WORD_WIDTH-1:0]    cam_data,
  input  logic                     fifo_full,
  output logic [WORD_WIDTH-1:0]    word_out,
  output logic                     we,
  output logic                     frame_active,
  output logic                     frame_done,
  output logic                     line_err,
  output logic [DROP_CNT_BITS-1:0] drop_count
);

  localparam int unsigned COL_W = $clog2(IMG_WIDTH + 1);
  localparam int unsigned ROW_W = $clog2(IMG_HEIGHT + 1);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT);

  localparam logic [1:0] SYNC      = 2'd0;
  localparam logic [1:0] WAIT_LINE = 2'd1;
  localparam logic [1:0] LINE      = 2'd2;
  localparam logic [1:0] DROP      = 2'd3;

  logic                     vsync_in_q, vsync_in_d;
  logic                     vsync_prev_q, vsync_prev_d;
  logic                     href_in_q, href_in_d;
  logic                     href_prev_q, href_prev_d;
  logic [WORD_WIDTH-1:0]    data_in_q, data_in_d;
  logic                     full_in_q, full_in_d;

  logic [1:0]               state_q, state_d;
  logic [COL_W-1:0]         col_q, col_d;
  logic [ROW_W-1:0]         row_q, row_d;
  logic                     phase_q, phase_d;
  logic                     over_q, over_d;

  logic [WORD_WIDTH-1:0]    word_out_q, word_out_d;
  logic                     we_q, we_d;
  logic                     frame_active_q, frame_active_d;
  logic                     frame_done_q, frame_done_d;
  logic                     line_err_q, line_err_d;
  logic [DROP_CNT_BITS-1:0] drop_count_q, drop_count_d;

  logic                     vs_rise, vs_fall, href_rise, line_start;
  logic                     byte_valid, write_pix, inc_drop;
  logic [COL_W-1:0]         cur_col;
  logic                     cur_phase, cur_over;

  always_comb begin
    vsync_in_d   = cam_vsync;
    vsync_prev_d = vsync_in_q;
    href_in_d    = cam_href;
    href_prev_d  = href_in_q;
    data_in_d    = cam_data;
    full_in_d    = fifo_full;

    state_d        = state_q;
    col_d          = col_q;
    row_d          = row_q;
    phase_d        = phase_q;
    over_d         = over_q;
    word_out_d     = word_out_q;
    we_d           = 1'b0;
    frame_active_d = frame_active_q;
    frame_done_d   = 1'b0;
    line_err_d     = 1'b0;
    inc_drop       = 1'b0;

    vs_rise    = vsync_in_q & ~vsync_prev_q;
    vs_fall    = ~vsync_in_q & vsync_prev_q;
    href_rise  = href_in_q & ~href_prev_q;
    line_start = (state_q == WAIT_LINE) && href_rise && !vs_rise;

    // The href rising edge already carries the first Y byte, so it is
    // consumed in the same cycle as if LINE had been entered with col=0,
    // byte_phase=0.
    byte_valid = line_start || ((state_q == LINE) && href_in_q);
    cur_col    = (state_q == LINE) ? col_q   : '0;
    cur_phase  = (state_q == LINE) ? phase_q : 1'b0;
    cur_over   = (state_q == LINE) ? over_q  : 1'b0;

`ifdef CAPTURE_DECIMATE_EN
    write_pix = ~cur_col[0] & ~row_q[0];
`else
    write_pix = 1'b1;
`endif

    case (state_q)
      SYNC: begin
        if (vs_fall) begin
          state_d        = WAIT_LINE;
          row_d          = '0;
          frame_active_d = 1'b1;
        end
      end
      WAIT_LINE: begin
        if (vs_rise) begin
          // Short frame: vsync already rose, so no DROP wait is needed.
          inc_drop       = 1'b1;
          frame_active_d = 1'b0;
          state_d        = SYNC;
        end else if (line_start) begin
          state_d = LINE;
        end
      end
      LINE: begin
        if (!href_in_q) begin
          if (col_q != COL_MAX || over_q) begin
            line_err_d     = 1'b1;
            inc_drop       = 1'b1;
            frame_active_d = 1'b0;
            state_d        = DROP;
          end else begin
            row_d = row_q + ROW_W'(1);
            if (row_q + ROW_W'(1) == ROW_MAX) begin
              frame_done_d   = 1'b1;
              frame_active_d = 1'b0;
              state_d        = SYNC;
            end else begin
              state_d = WAIT_LINE;
            end
          end
        end
      end
      default: begin
        if (vs_rise) state_d = SYNC;
      end
    endcase

    if (byte_valid) begin
      phase_d = ~cur_phase;
      col_d   = cur_col;
      over_d  = cur_over;
      if (!cur_phase) begin
        if (cur_col >= COL_MAX) begin
          over_d = 1'b1;
        end else begin
          col_d = cur_col + COL_W'(1);
          if (write_pix) begin
            if (full_in_q) begin
              inc_drop       = 1'b1;
              frame_active_d = 1'b0;
              state_d        = DROP;
            end else begin
              we_d       = 1'b1;
              word_out_d = data_in_q;
            end
          end
        end
      end
    end

    drop_count_d = drop_count_q;
    if (inc_drop && (drop_count_q != '1)) drop_count_d = drop_count_q + DROP_CNT_BITS'(1);
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      vsync_in_q     <= 1'b0;
      vsync_prev_q   <= 1'b0;
      href_in_q      <= 1'b0;
      href_prev_q    <= 1'b0;
      data_in_q      <= '0;
      full_in_q      <= 1'b0;
      state_q        <= SYNC;
      col_q          <= '0;
      row_q          <= '0;
      phase_q        <= 1'b0;
      over_q         <= 1'b0;
      word_out_q     <= '0;
      we_q           <= 1'b0;
      frame_active_q <= 1'b0;
      frame_done_q   <= 1'b0;
      line_err_q     <= 1'b0;
      drop_count_q   <= '0;
    end else begin
      vsync_in_q     <= vsync_in_d;
      vsync_prev_q   <= vsync_prev_d;
      href_in_q      <= href_in_d;
      href_prev_q    <= href_prev_d;
      data_in_q      <= data_in_d;
      full_in_q      <= full_in_d;
      state_q        <= state_d;
      col_q          <= col_d;
      row_q          <= row_d;
      phase_q        <= phase_d;
      over_q         <= over_d;
      word_out_q     <= word_out_d;
      we_q           <= we_d;
      frame_active_q <= frame_active_d;
      frame_done_q   <= frame_done_d;
      line_err_q     <= line_err_d;
      drop_count_q   <= drop_count_d;
    end
  end

  assign word_out     = word_out_q;
  assign we           = we_q;
  assign frame_active = frame_active_q;
  assign frame_done   = frame_done_q;
  assign line_err     = line_err_q;
  assign drop_count   = drop_count_q;

endmodule
